// File: rtl/led_chase_game_pkg.sv
// Shared types and constants for the LED chase game.
// Holds the game state enum, the MODE encodings and a counter-width helper
// used to size the step, interval and hold counters.
package chase_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WIN  = 2'd1,
    MISS = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_WRAP   = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;

  // Bits needed to hold any value 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/led_chase_game_if.sv
// Board-pin bundle for the LED chase game.
// Ports: SWITCHES (raw switch levels), MODE (0 wrap / 1 bounce) into the game;
// LEDS (LED drive), SCORE (current score), LOCKED (game finished) out of it.
interface led_chase_game_if #(
  parameter int N  = 4,
  parameter int SW = 2
);
  logic [N-1:0]  SWITCHES;
  logic          MODE;
  logic [N-1:0]  LEDS;
  logic [SW-1:0] SCORE;
  logic          LOCKED;

  // Board / stimulus side drives switches and mode, observes the display.
  modport master (output SWITCHES, MODE, input LEDS, SCORE, LOCKED);
  // Game side.
  modport slave  (input SWITCHES, MODE, output LEDS, SCORE, LOCKED);
endinterface

// File: rtl/led_chase_game_edge_sync.sv
// Two-flop synchroniser with rising-edge detect for N raw switch inputs.
// Latency: a rise before posedge k shows on edges after posedge k, for one cycle.
// Ports: HzClock, RST (sync, active-high), d (raw levels), edges (one-cycle rise pulses).
module edge_sync #(
  parameter int N = 4
) (
  input  logic         HzClock,
  input  logic         RST,
  input  logic [N-1:0] d,
  output logic [N-1:0] edges
);

  logic [N-1:0] r_q1;
  logic [N-1:0] r_q2;

  always_ff @(posedge HzClock) begin
    if (RST) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      r_q1 <= d;
      r_q2 <= r_q1;
    end
  end

  assign edges = r_q1 & ~r_q2;

endmodule

// File: rtl/led_chase_game.sv
// One-hot LED chase game: hit the lit LED's switch to score, wrong switch is a miss.
// Ports: HzClock, RST (sync, active-high), bus (slave side: SWITCHES, MODE in;
// LEDS, SCORE, LOCKED out). Switch response appears two posedges after the rise.
module led_chase_game
  import chase_pkg::*;
#(
  parameter int N          = 4,
  parameter int STEP_INIT  = 8,
  parameter int STEP_MIN   = 2,
  parameter int STEP_DEC   = 1,
  parameter int WIN_HOLD   = 4,
  parameter int MISS_HOLD  = 2,
  parameter int WIN_TARGET = 3,
  parameter int PENALTY    = 1
) (
  input logic         HzClock,
  input logic         RST,
  led_chase_game_if.slave bus
);

  localparam int IW = cnt_w(STEP_INIT);
  localparam int HW = cnt_w((WIN_HOLD > MISS_HOLD) ? WIN_HOLD : MISS_HOLD);
  localparam int SW = cnt_w(WIN_TARGET);

  state_t        r_state;
  logic [N-1:0]  r_pos;
  logic          r_dir_up;
  logic [IW-1:0] r_step_cnt;
  logic [IW-1:0] r_interval;
  logic [HW-1:0] r_hold_cnt;
  logic [SW-1:0] r_score;

  logic [N-1:0]  w_edge;
  logic          w_step_due;
  logic          w_go_up;
  logic [N-1:0]  w_bounce_pos;
  logic          w_bounce_up;

  edge_sync #(.N(N)) u_sync (
    .HzClock (HzClock),
    .RST     (RST),
    .d       (bus.SWITCHES),
    .edges   (w_edge)
  );

  assign w_step_due = (r_step_cnt == r_interval - IW'(1));

  // Bounce move. An end LED always turns the light back inward, even if the
  // stored direction is stale (e.g. just switched over from wrap mode).
  // The new direction flips on the step that lands on an end.
  always_comb begin
    w_go_up = r_dir_up;
    if (r_pos[N-1])
      w_go_up = 1'b0;
    else if (r_pos[0])
      w_go_up = 1'b1;
    w_bounce_pos = w_go_up ? (r_pos << 1) : (r_pos >> 1);
    w_bounce_up  = w_go_up;
    if (w_bounce_pos[N-1])
      w_bounce_up = 1'b0;
    else if (w_bounce_pos[0])
      w_bounce_up = 1'b1;
  end

  always_ff @(posedge HzClock) begin
    if (RST) begin
      r_state    <= RUN;
      r_pos      <= N'(1);
      r_dir_up   <= 1'b1;
      r_step_cnt <= '0;
      r_interval <= IW'(STEP_INIT);
      r_hold_cnt <= '0;
      r_score    <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_edge != '0) begin
            // Any switch activity suppresses this cycle's step.
            r_hold_cnt <= '0;
            if (w_edge == r_pos) begin
              r_state <= WIN;
              if (r_score != SW'(WIN_TARGET))
                r_score <= r_score + SW'(1);
              if (int'(r_interval) >= STEP_MIN + STEP_DEC)
                r_interval <= r_interval - IW'(STEP_DEC);
              else
                r_interval <= IW'(STEP_MIN);
            end else begin
              r_state <= MISS;
              if (PENALTY != 0 && r_score != '0)
                r_score <= r_score - SW'(1);
            end
          end else if (w_step_due) begin
            r_step_cnt <= '0;
            if (bus.MODE == MODE_BOUNCE) begin
              r_pos    <= w_bounce_pos;
              r_dir_up <= w_bounce_up;
            end else begin
              r_pos    <= {r_pos[N-2:0], r_pos[N-1]};
              r_dir_up <= 1'b1;
            end
          end else begin
            r_step_cnt <= r_step_cnt + IW'(1);
          end
        end
        WIN: begin
          if (r_hold_cnt == HW'(WIN_HOLD - 1)) begin
            if (r_score == SW'(WIN_TARGET)) begin
              r_state <= DONE;
            end else begin
              r_state    <= RUN;
              r_pos      <= N'(1);
              r_dir_up   <= 1'b1;
              r_step_cnt <= '0;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        MISS: begin
          if (r_hold_cnt == HW'(MISS_HOLD - 1)) begin
            r_state    <= RUN;
            r_step_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        default: begin
          r_state <= DONE;
        end
      endcase
    end
  end

  always_comb begin
    bus.LEDS = '1;
    case (r_state)
      RUN:     bus.LEDS = r_pos;
      MISS:    bus.LEDS = '0;
      default: bus.LEDS = '1;
    endcase
  end

  assign bus.SCORE  = r_score;
  assign bus.LOCKED = (r_state == DONE);

endmodule

// File: tb/tb_led_chase_game.sv
module tb_led_chase_game;

  localparam int N          = 4;
  localparam int STEP_INIT  = 4;
  localparam int STEP_MIN   = 2;
  localparam int STEP_DEC   = 1;
  localparam int WIN_HOLD   = 3;
  localparam int MISS_HOLD  = 2;
  localparam int WIN_TARGET = 2;
  localparam int PENALTY    = 1;
  localparam int SW         = 2;

  localparam int PH_RUN  = 0;
  localparam int PH_WIN  = 1;
  localparam int PH_MISS = 2;
  localparam int PH_DONE = 3;

  typedef struct packed {
    logic [N-1:0]  leds;
    logic [SW-1:0] score;
    logic          locked;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_chase_game_if #(.N(N), .SW(SW)) ifc ();

  led_chase_game #(
    .N(N), .STEP_INIT(STEP_INIT), .STEP_MIN(STEP_MIN), .STEP_DEC(STEP_DEC),
    .WIN_HOLD(WIN_HOLD), .MISS_HOLD(MISS_HOLD), .WIN_TARGET(WIN_TARGET), .PENALTY(PENALTY)
  ) dut (
    .HzClock (clk),
    .RST     (rst),
    .bus     (ifc)
  );

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: lit LED index, travel direction, elapsed cycles in the
  // current step, step period, cycles left in a flash, score.
  int         m_phase, m_idx, m_elapsed, m_period, m_left, m_score;
  bit         m_up;
  logic [N-1:0] m_q1, m_q2;

  task automatic model_reset();
    m_phase = PH_RUN; m_idx = 0; m_up = 1'b1; m_elapsed = 0;
    m_period = STEP_INIT; m_left = 0; m_score = 0; m_q1 = '0; m_q2 = '0;
  endtask

  task automatic model_advance(input logic bounce);
    if (!bounce) begin
      m_idx = (m_idx + 1) % N;
      m_up  = 1'b1;
    end else begin
      if (m_idx == N - 1)  m_up = 1'b0;
      else if (m_idx == 0) m_up = 1'b1;
      m_idx = m_up ? m_idx + 1 : m_idx - 1;
      if (m_idx == N - 1)  m_up = 1'b0;
      if (m_idx == 0)      m_up = 1'b1;
    end
  endtask

  task automatic model_step();
    logic [N-1:0] e;
    logic [N-1:0] lit;
    if (rst) begin
      model_reset();
      return;
    end
    e    = m_q1 & ~m_q2;
    m_q2 = m_q1;
    m_q1 = ifc.SWITCHES;
    lit  = N'(1 << m_idx);
    case (m_phase)
      PH_RUN: begin
        if (e != '0) begin
          if (e == lit) begin
            m_phase  = PH_WIN;
            m_left   = WIN_HOLD;
            m_score  = (m_score + 1 > WIN_TARGET) ? WIN_TARGET : m_score + 1;
            m_period = (m_period - STEP_DEC < STEP_MIN) ? STEP_MIN : m_period - STEP_DEC;
          end else begin
            m_phase = PH_MISS;
            m_left  = MISS_HOLD;
            if (PENALTY == 1 && m_score > 0) m_score = m_score - 1;
          end
        end else begin
          m_elapsed = m_elapsed + 1;
          if (m_elapsed == m_period) begin
            m_elapsed = 0;
            model_advance(ifc.MODE);
          end
        end
      end
      PH_WIN: begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_score == WIN_TARGET) begin
            m_phase = PH_DONE;
          end else begin
            m_phase = PH_RUN; m_idx = 0; m_up = 1'b1; m_elapsed = 0;
          end
        end
      end
      PH_MISS: begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_phase = PH_RUN; m_elapsed = 0;
        end
      end
      default: ;
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t r;
    r.leds   = (m_phase == PH_RUN) ? N'(1 << m_idx) : (m_phase == PH_MISS) ? '0 : '1;
    r.score  = SW'(m_score);
    r.locked = (m_phase == PH_DONE);
    return r;
  endfunction

  // One clock: the DUT and the model both consume the inputs set before this edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.SWITCHES = '0;
    tick();
    rst = 1'b0;
  endtask

  // Advance until LED k has just lit (first cycle of its step).
  task automatic until_lit(input int k);
    for (int i = 0; i < 64; i++) begin
      if (m_phase == PH_RUN && m_idx == k && m_elapsed == 0) break;
      tick();
    end
  endtask

  // Monitor: every cycle the DUT presents a display state; compare to the queue head.
  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g.leds = ifc.LEDS; g.score = ifc.SCORE; g.locked = ifc.LOCKED;
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL display t=%0t: got leds=%b score=%0d locked=%b, want leds=%b score=%0d locked=%b",
                   $time, g.leds, g.score, g.locked, e.leds, e.score, e.locked);
        end
      end
    end
  end

  initial begin
    int r;
    ifc.SWITCHES = '0;
    ifc.MODE     = 1'b0;
    model_reset();

    // Wrap chase from reset.
    do_reset(); ticks(22);
    // Bounce chase from reset.
    ifc.MODE = 1'b1; do_reset(); ticks(36);
    // Hit on LED2, then a second hit to lock, then switch noise, then reset.
    ifc.MODE = 1'b0; do_reset();
    until_lit(2); ifc.SWITCHES = 4'b0100; ticks(8);
    ifc.SWITCHES = '0; until_lit(1); ifc.SWITCHES = 4'b0010; ticks(8);
    ifc.SWITCHES = 4'b1111; ticks(2); ifc.SWITCHES = '0; ticks(2);
    ifc.SWITCHES = 4'b0001; ticks(3);
    do_reset(); ifc.SWITCHES = '0; ticks(10);
    // Wrong switch at score 0.
    do_reset(); ifc.SWITCHES = 4'b1000; ticks(12); ifc.SWITCHES = '0;
    // Two switches including the lit one: a miss.
    do_reset(); ifc.SWITCHES = 4'b0011; ticks(8); ifc.SWITCHES = '0;
    // Reset during the win flash.
    do_reset(); ifc.SWITCHES = 4'b0001; ticks(3); rst = 1'b1; tick(); rst = 1'b0;
    ifc.SWITCHES = '0; ticks(12);

    // Randomised play.
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 99);
      rst = (r == 0);
      if (r >= 1 && r <= 3)        ifc.MODE = ~ifc.MODE;
      else if (r >= 4 && r <= 23)  ifc.SWITCHES = '0;
      else if (r >= 24 && r <= 33) ifc.SWITCHES = N'(1 << m_idx);
      else if (r >= 34 && r <= 38) ifc.SWITCHES = N'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0;
    ticks(2);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
